// File: rtl/alu_pkg.sv
// Shared types for the alu_core datapath: operation select codes and status flags.
package alu_pkg;

    localparam int unsigned ALU_SEL_W = 3;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_MUL  = 3'd2,
        ALU_DIV  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_NOT  = 3'd6,
        ALU_RSVD = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result plus raw carry/overflow information.
// Carry/overflow outputs exist only when ALU_FLAGS_EN is defined.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [ALU_SEL_W-1:0] sel,
    input  logic [N-1:0]         op1,
    input  logic [N-1:0]         op2,
    output logic [N-1:0]         res
`ifdef ALU_FLAGS_EN
    ,
    output logic                 carry,
    output logic                 ovf
`endif
);

`ifdef ALU_FLAGS_EN
    logic [N:0]     sum_w;
    logic [N:0]     dif_w;
    logic [2*N-1:0] prod_w;
    logic [2*N-1:0] shr_w;
    logic           shout;

    // Widened operations keep carry, borrow, high product and shifted-out bits visible.
    assign sum_w  = {1'b0, op1} + {1'b0, op2};
    assign dif_w  = {1'b0, op1} - {1'b0, op2};
    assign prod_w = {{N{1'b0}}, op1} * {{N{1'b0}}, op2};
    assign shr_w  = {op1, {N{1'b0}}} >> op2;
    // Shifts of N or more lose every bit, some of which may fall past the low half.
    assign shout  = (op2 >= N'(N)) ? (|op1) : (|shr_w[N-1:0]);

    always_comb begin
        res   = sum_w[N-1:0];
        carry = sum_w[N];
        ovf   = (op1[N-1] == op2[N-1]) && (sum_w[N-1] != op1[N-1]);
        case (alu_op_e'(sel))
            ALU_SUB: begin
                res   = dif_w[N-1:0];
                carry = dif_w[N];
                ovf   = (op1[N-1] != op2[N-1]) && (dif_w[N-1] != op1[N-1]);
            end
            ALU_MUL: begin
                res   = prod_w[N-1:0];
                carry = |prod_w[2*N-1:N];
                ovf   = 1'b0;
            end
            ALU_DIV: begin
                res   = shr_w[2*N-1:N];
                carry = shout;
                ovf   = 1'b0;
            end
            ALU_AND: begin
                res   = op1 & op2;
                carry = 1'b0;
                ovf   = 1'b0;
            end
            ALU_OR: begin
                res   = op1 | op2;
                carry = 1'b0;
                ovf   = 1'b0;
            end
            ALU_NOT: begin
                res   = ~op1;
                carry = 1'b0;
                ovf   = 1'b0;
            end
            default: ;
        endcase
    end
`else
    // Shift by N or more naturally yields zero.
    always_comb begin
        res = op1 + op2;
        case (alu_op_e'(sel))
            ALU_SUB: res = op1 - op2;
            ALU_MUL: res = op1 * op2;
            ALU_DIV: res = op1 >> op2;
            ALU_AND: res = op1 & op2;
            ALU_OR:  res = op1 | op2;
            ALU_NOT: res = ~op1;
            default: res = op1 + op2;
        endcase
    end
`endif

endmodule

// File: rtl/alu_core.sv
// ALU top: combinational result q plus a capture register for result and flags.
// Flag generation is built only when ALU_FLAGS_EN is defined; otherwise flags read 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALU_SEL_W-1:0] ALUSEL,
    input  logic [N-1:0]         op1,
    input  logic [N-1:0]         op2,
    input  logic                 in_valid,
    output logic [N-1:0]         q,
    output logic [N-1:0]         q_r,
    output logic                 out_valid,
    output logic                 flag_z,
    output logic                 flag_n,
    output logic                 flag_c,
    output logic                 flag_v
);

    logic [N-1:0] res;

`ifdef ALU_FLAGS_EN
    logic       carry;
    logic       ovf;
    alu_flags_t flags_c;
    alu_flags_t flags_r;
`endif

    alu_comb #(
        .N(N)
    ) u_comb (
        .sel   (ALUSEL),
        .op1   (op1),
        .op2   (op2),
        .res   (res)
`ifdef ALU_FLAGS_EN
        ,
        .carry (carry),
        .ovf   (ovf)
`endif
    );

    assign q = res;

    // Result capture; out_valid marks the cycle after a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                q_r <= res;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        flags_c   = '0;
        flags_c.z = (res == '0);
        flags_c.n = res[N-1];
        flags_c.c = carry;
        flags_c.v = ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= '0;
        end else if (in_valid) begin
            flags_r <= flags_c;
        end
    end

    assign flag_z = flags_r.z;
    assign flag_n = flags_r.n;
    assign flag_c = flags_r.c;
    assign flag_v = flags_r.v;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (N=32): directed plan vectors plus random
// stimulus against an arithmetic reference model; flags checked per ALU_FLAGS_EN.
module tb_alu_core;

    localparam int unsigned N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    ALUSEL = 3'd0;
    logic [N-1:0]  op1 = '0;
    logic [N-1:0]  op2 = '0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  q;
    logic [N-1:0]  q_r;
    logic          out_valid;
    logic          flag_z, flag_n, flag_c, flag_v;

    int checks = 0;
    int errors = 0;

    // Expected registered state, updated whenever a capture is expected.
    logic [N-1:0] exp_qr = '0;
    logic [3:0]   exp_fr = '0;

    alu_core #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .ALUSEL    (ALUSEL),
        .op1       (op1),
        .op2       (op2),
        .in_valid  (in_valid),
        .q         (q),
        .q_r       (q_r),
        .out_valid (out_valid),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    // Reference model: 64-bit plain arithmetic, flags returned as {z,n,c,v}.
    function automatic void ref_alu(input logic [2:0] sel, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [3:0] f);
        logic [63:0] ua, ub, wide, d;
        longint      sa, sb, sr;
        logic        c, v;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        c  = 1'b0;
        v  = 1'b0;
        case (sel)
            3'd1: begin
                wide = ua - ub;
                r    = wide[31:0];
                c    = (ua < ub);
                sr   = sa - sb;
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: begin
                wide = ua * ub;
                r    = wide[31:0];
                c    = (wide > 64'hFFFF_FFFF);
            end
            3'd3: begin
                if (ub >= 64'd32) begin
                    r = 32'd0;
                    c = (a != 32'd0);
                end else begin
                    d = 64'd1 << ub;
                    r = 32'(ua / d);
                    c = ((ua % d) != 64'd0);
                end
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = ~a;
            default: begin
                wide = ua + ub;
                r    = wide[31:0];
                c    = (wide > 64'hFFFF_FFFF);
                sr   = sa + sb;
                v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        endcase
        f = {(r == 32'd0), r[31], c, v};
`ifndef ALU_FLAGS_EN
        f = 4'b0000;
`endif
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (q_r !== '0) begin
            errors++;
            $display("FAIL reset_q_r got %h exp %h", q_r, 32'd0);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b exp 0", out_valid);
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {flag_z, flag_n, flag_c, flag_v});
        end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_qr = '0;
        exp_fr = '0;
    endtask

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    task automatic test_directed();
        vec_t       tbl [13];
        logic [3:0] ef;
        tbl[0]  = {3'd0, 32'd30, 32'd20, 32'd50, 4'b0000};
        tbl[1]  = {3'd1, 32'd30, 32'd20, 32'd10, 4'b0000};
        tbl[2]  = {3'd1, 32'd20, 32'd30, 32'hFFFF_FFF6, 4'b0110};
        tbl[3]  = {3'd2, 32'd30, 32'd20, 32'd600, 4'b0000};
        tbl[4]  = {3'd2, 32'd65536, 32'd65536, 32'd0, 4'b1010};
        tbl[5]  = {3'd3, 32'd30, 32'd1, 32'd15, 4'b0000};
        tbl[6]  = {3'd3, 32'd30, 32'd32, 32'd0, 4'b1010};
        tbl[7]  = {3'd3, 32'd31, 32'd1, 32'd15, 4'b0010};
        tbl[8]  = {3'd4, 32'd30, 32'd20, 32'd20, 4'b0000};
        tbl[9]  = {3'd5, 32'd30, 32'd20, 32'd30, 4'b0000};
        tbl[10] = {3'd7, 32'd30, 32'd20, 32'd50, 4'b0000};
        tbl[11] = {3'd6, 32'hFFFF_FFFF, 32'd5, 32'd0, 4'b1000};
        tbl[12] = {3'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101};
        for (int i = 0; i < 13; i++) begin
            ALUSEL   = tbl[i].sel;
            op1      = tbl[i].a;
            op2      = tbl[i].b;
            in_valid = 1'b1;
            ef       = tbl[i].f;
`ifndef ALU_FLAGS_EN
            ef = 4'b0000;
`endif
            #1;
            checks++;
            if (q !== tbl[i].r) begin
                errors++;
                $display("FAIL directed_q[%0d] got %h exp %h", i, q, tbl[i].r);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            exp_qr   = tbl[i].r;
            exp_fr   = ef;
            checks++;
            if (q_r !== exp_qr || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed_qr[%0d] got %h/%b exp %h/1", i, q_r, out_valid, exp_qr);
            end
            checks++;
            if ({flag_z, flag_n, flag_c, flag_v} !== exp_fr) begin
                errors++;
                $display("FAIL directed_flags[%0d] got %b exp %b", i,
                         {flag_z, flag_n, flag_c, flag_v}, exp_fr);
            end
        end
    endtask

    // Random operations with random strobes; registered outputs must hold when idle.
    task automatic test_random(input int iters, input bit always_valid);
        logic [31:0] a, b, r;
        logic [2:0]  s;
        logic [3:0]  f;
        logic        iv;
        for (int i = 0; i < iters; i++) begin
            s  = always_valid ? 3'(i) : 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 64)) : 32'($urandom);
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            iv = always_valid ? 1'b1 : 1'($urandom_range(0, 1));
            ref_alu(s, a, b, r, f);
            ALUSEL   = s;
            op1      = a;
            op2      = b;
            in_valid = iv;
            #1;
            checks++;
            if (q !== r) begin
                errors++;
                $display("FAIL random_q sel %0d a %h b %h got %h exp %h", s, a, b, q, r);
            end
            if (iv) begin
                exp_qr = r;
                exp_fr = f;
            end
            @(posedge clk);
            #1;
            checks++;
            if (q_r !== exp_qr) begin
                errors++;
                $display("FAIL random_qr sel %0d a %h b %h got %h exp %h", s, a, b, q_r, exp_qr);
            end
            checks++;
            if (out_valid !== iv) begin
                errors++;
                $display("FAIL random_out_valid got %b exp %b", out_valid, iv);
            end
            checks++;
            if ({flag_z, flag_n, flag_c, flag_v} !== exp_fr) begin
                errors++;
                $display("FAIL random_flags sel %0d a %h b %h got %b exp %b", s, a, b,
                         {flag_z, flag_n, flag_c, flag_v}, exp_fr);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        ALUSEL   = 3'd0;
        op1      = 32'h7FFF_FFFF;
        op2      = 32'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (q_r !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_qr got %h/%b exp 0/0", q_r, out_valid);
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_flags got %b exp 0000", {flag_z, flag_n, flag_c, flag_v});
        end
        checks++;
        if (q !== 32'h8000_0000) begin
            errors++;
            $display("FAIL async_reset_q_comb got %h exp 80000000", q);
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (q_r !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_capture got %h/%b exp 0/0", q_r, out_valid);
        end
        rst    = 1'b0;
        op1    = 32'd30;
        op2    = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_qr   = 32'd50;
        exp_fr   = 4'b0000;
        checks++;
        if (q_r !== 32'd50 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_capture got %h/%b exp 00000032/1", q_r, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(300, 1'b0);
        test_random(16, 1'b1);
        test_async_reset();
        test_random(40, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
